// File: rtl/pwr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pwr_seq_ctrl
//   N-step power-rail sequencer. It ramps the rail enables up one step at a
//   time, with a delay class per step. It ramps them down highest-first. It
//   can reverse direction mid-sequence. It also generates the system init
//   reset and a ROIC reset pulse.
//
// Ports
//   fsm_clk     in   sequencer clock
//   reset       in   asynchronous active-high reset
//   en_pwr_off  in   async level: 1 requests rails off, 0 requests rails on
//   pg_in       in   async power-good per rail (NUM_STEPS bits)
//   step_en     out  rail enables, thermometer coded, bit k = step k
//   init_rst    out  high until the first complete power-up
//   roic_reset  out  RST_PULSE_W-cycle pulse after step_en[RST_STEP] rises
//   busy        out  high while ramping up or down
//   fault       out  high while in the power-good fault state
//
// Build option
//   PWR_SEQ_PG_CHECK_EN : when defined, power-good supervision is enabled
//   (ramp stall with timeout, loss of power-good while on). When undefined,
//   pg_in is ignored and fault is tied low.
// ---------------------------------------------------------------------------
module pwr_seq_ctrl #(
  parameter int unsigned           NUM_STEPS   = 6,
  parameter int unsigned           CNT_W       = 25,
  parameter int unsigned           DLY_UP      = 1000,
  parameter int unsigned           DLY_DN      = 1000,
  parameter int unsigned           DLY_SLOW    = 3000,
  parameter logic [NUM_STEPS-1:0]  SLOW_MASK   = 6'b010000,
  parameter int unsigned           RST_STEP    = 4,
  parameter int unsigned           RST_PULSE_W = 4,
  parameter int unsigned           PG_TIMEOUT  = 5000
) (
  input  logic                 fsm_clk,
  input  logic                 reset,
  input  logic                 en_pwr_off,
  input  logic [NUM_STEPS-1:0] pg_in,
  output logic [NUM_STEPS-1:0] step_en,
  output logic                 init_rst,
  output logic                 roic_reset,
  output logic                 busy,
  output logic                 fault
);

  localparam int unsigned KW     = $clog2(NUM_STEPS + 1);
  localparam int unsigned PW_W   = $clog2(RST_PULSE_W + 1);
  localparam int unsigned WAIT_W = $clog2(PG_TIMEOUT + 2);

  localparam logic [CNT_W-1:0]  DLY_UP_C    = CNT_W'(DLY_UP);
  localparam logic [CNT_W-1:0]  DLY_DN_C    = CNT_W'(DLY_DN);
  localparam logic [CNT_W-1:0]  DLY_SLOW_C  = CNT_W'(DLY_SLOW);
  localparam logic [PW_W-1:0]   PULSE_LD_C  = PW_W'(RST_PULSE_W - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM_C  = WAIT_W'(PG_TIMEOUT);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_RAMP_UP = 3'd1,
    ST_ON      = 3'd2,
    ST_RAMP_DN = 3'd3,
    ST_FAULT   = 3'd4
  } state_e;

  // synchronisers
  logic                 en_sync_q;
  logic                 req_off_q;
  logic [NUM_STEPS-1:0] pg_sync_q;
  logic [NUM_STEPS-1:0] pg_s_q;
  logic [NUM_STEPS-1:0] pg_prev_q;

  // sequencer state
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_STEPS-1:0] step_en_q, step_en_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 busy_q, busy_d;
  logic                 init_rst_q, init_rst_d;
  logic                 fault_q, fault_d;

  // ROIC pulse
  logic                 rst_prev_q;
  logic [PW_W-1:0]      pulse_cnt_q;
  logic                 roic_q;

  logic [KW-1:0]        k_s;
  logic [CNT_W-1:0]     dly_s;
  logic                 at_term_s;
  logic                 pg_ok_s;
  logic                 pg_tmo_s;
  logic                 pg_fall_s;
  logic                 rst_rise_s;

  // Two-stage synchronisers. The off-request resets to "off" so that
  // power-up after reset always takes the full synchroniser latency.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      en_sync_q <= 1'b1;
      req_off_q <= 1'b1;
      pg_sync_q <= '0;
      pg_s_q    <= '0;
      pg_prev_q <= '0;
    end else begin
      en_sync_q <= en_pwr_off;
      req_off_q <= en_sync_q;
      pg_sync_q <= pg_in;
      pg_s_q    <= pg_sync_q;
      pg_prev_q <= pg_s_q;
    end
  end

  // The number of enabled rails is the index of the next step to raise.
  always_comb begin
    k_s = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      k_s = k_s + KW'(step_en_q[i]);
    end
  end

  // Select the ramp-up delay class of the next step.
  always_comb begin
    dly_s = DLY_UP_C;
    for (int i = 0; i < NUM_STEPS; i++) begin
      dly_s = ((k_s == KW'(i)) && SLOW_MASK[i]) ? DLY_SLOW_C : dly_s;
    end
  end

  assign at_term_s = (cnt_q == dly_s);

`ifdef PWR_SEQ_PG_CHECK_EN
  // Step k may rise only once rail k-1 reports power-good.
  always_comb begin
    pg_ok_s = 1'b1;
    for (int i = 1; i < NUM_STEPS; i++) begin
      pg_ok_s = (k_s == KW'(i)) ? pg_s_q[i-1] : pg_ok_s;
    end
  end

  assign pg_tmo_s  = at_term_s && !pg_ok_s && (wait_q >= WAIT_LIM_C);
  assign pg_fall_s = |(pg_prev_q & ~pg_s_q);
`else
  assign pg_ok_s   = 1'b1;
  assign pg_tmo_s  = 1'b0;
  assign pg_fall_s = 1'b0;
`endif

  // Next-state logic. Fault beats reversal, reversal beats a counter terminal.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_en_d = step_en_q;
    wait_d    = wait_q;
    case (state_q)
      ST_OFF: begin
        cnt_d  = '0;
        wait_d = '0;
        if (!req_off_q) begin
          state_d = ST_RAMP_UP;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_RAMP_UP: begin
        if (pg_tmo_s) begin
          state_d   = ST_FAULT;
          step_en_d = '0;
          cnt_d     = '0;
          wait_d    = '0;
        end else if (req_off_q) begin
          state_d = ST_RAMP_DN;
          cnt_d   = '0;
          wait_d  = '0;
        end else if (k_s == KW'(NUM_STEPS)) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (at_term_s) begin
          if (pg_ok_s) begin
            step_en_d = {step_en_q[NUM_STEPS-2:0], 1'b1};
            cnt_d     = '0;
            wait_d    = '0;
          end else begin
            // Counter parks at the terminal value while power-good is awaited.
            wait_d = wait_q + WAIT_W'(1'b1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_ON: begin
        cnt_d = '0;
        if (pg_fall_s) begin
          state_d   = ST_FAULT;
          step_en_d = '0;
        end else if (req_off_q) begin
          state_d = ST_RAMP_DN;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_RAMP_DN: begin
        if (!req_off_q) begin
          state_d = ST_RAMP_UP;
          cnt_d   = '0;
          wait_d  = '0;
        end else if (step_en_q == '0) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else if (cnt_q == DLY_DN_C) begin
          step_en_d = {1'b0, step_en_q[NUM_STEPS-1:1]};
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      ST_FAULT: begin
        step_en_d = '0;
        cnt_d     = '0;
        wait_d    = '0;
        if (req_off_q) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d   = ST_OFF;
        step_en_d = '0;
        cnt_d     = '0;
        wait_d    = '0;
      end
    endcase

    busy_d     = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DN);
    fault_d    = (state_d == ST_FAULT);
    // Sticky: once the first power-up completes, only reset raises it again.
    init_rst_d = (state_d == ST_ON) ? 1'b0 : init_rst_q;
  end

  // Sequencer registers, including all registered outputs.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OFF;
      cnt_q      <= '0;
      step_en_q  <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      init_rst_q <= 1'b1;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_en_q  <= step_en_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      init_rst_q <= init_rst_d;
      fault_q    <= fault_d;
    end
  end

  assign rst_rise_s = step_en_q[RST_STEP] & ~rst_prev_q;

  // ROIC reset pulse: a rise of the trigger step (re)loads the pulse counter.
  always_ff @(posedge fsm_clk or posedge reset) begin
    if (reset) begin
      rst_prev_q  <= 1'b0;
      pulse_cnt_q <= '0;
      roic_q      <= 1'b0;
    end else begin
      rst_prev_q <= step_en_q[RST_STEP];
      if (rst_rise_s) begin
        pulse_cnt_q <= PULSE_LD_C;
        roic_q      <= 1'b1;
      end else if (pulse_cnt_q != '0) begin
        pulse_cnt_q <= pulse_cnt_q - PW_W'(1'b1);
        roic_q      <= 1'b1;
      end else begin
        pulse_cnt_q <= '0;
        roic_q      <= 1'b0;
      end
    end
  end

  assign step_en    = step_en_q;
  assign init_rst   = init_rst_q;
  assign roic_reset = roic_q;
  assign busy       = busy_q;

`ifdef PWR_SEQ_PG_CHECK_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
  // Supervision logic is not built; these values have no consumer.
  logic unused_pg_s;
  assign unused_pg_s = ^{pg_s_q, pg_prev_q, fault_q};
`endif

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pwr_seq_ctrl
//   Directed self-checking bench for pwr_seq_ctrl, configured with
//   NUM_STEPS=4, DLY_UP=3, DLY_DN=2, DLY_SLOW=7, SLOW_MASK=4'b0100,
//   RST_STEP=2, RST_PULSE_W=4, PG_TIMEOUT=10.
// ---------------------------------------------------------------------------
module tb_pwr_seq_ctrl;

  logic       fsm_clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_pwr_off = 1'b0;
  logic [3:0] pg_in = 4'b1111;
  logic [3:0] step_en;
  logic       init_rst;
  logic       roic_reset;
  logic       busy;
  logic       fault;

  int checks = 0;
  int failures = 0;

  pwr_seq_ctrl #(
    .NUM_STEPS  (4),
    .CNT_W      (8),
    .DLY_UP     (3),
    .DLY_DN     (2),
    .DLY_SLOW   (7),
    .SLOW_MASK  (4'b0100),
    .RST_STEP   (2),
    .RST_PULSE_W(4),
    .PG_TIMEOUT (10)
  ) dut (
    .fsm_clk   (fsm_clk),
    .reset     (reset),
    .en_pwr_off(en_pwr_off),
    .pg_in     (pg_in),
    .step_en   (step_en),
    .init_rst  (init_rst),
    .roic_reset(roic_reset),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 fsm_clk = ~fsm_clk;

  // One active edge, then sample away from it.
  task automatic tick();
    @(posedge fsm_clk);
    #1;
  endtask

  // Advance until step_en changes (bounded). Reports the edge count, whether
  // every observed pattern was thermometer coded and whether busy stayed high.
  task automatic wait_step(output int n, output logic thermo_ok, output logic busy_ok);
    logic [3:0] prev;
    prev = step_en;
    n = 0;
    thermo_ok = 1'b1;
    busy_ok = 1'b1;
    do begin
      tick();
      n++;
      if ((step_en & (step_en + 4'd1)) != 4'd0) thermo_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while ((step_en === prev) && (n < 64));
  endtask

  // Advance until busy changes (bounded); report the edge count.
  task automatic wait_busy(output int n);
    logic prev;
    prev = busy;
    n = 0;
    do begin
      tick();
      n++;
    end while ((busy === prev) && (n < 64));
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    checks++; if (step_en !== 4'b0000) begin failures++; $display("FAIL reset.step_en got %b want 0000", step_en); end
    checks++; if (init_rst !== 1'b1) begin failures++; $display("FAIL reset.init_rst got %b want 1", init_rst); end
    checks++; if (roic_reset !== 1'b0) begin failures++; $display("FAIL reset.roic got %b want 0", roic_reset); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset.busy got %b want 0", busy); end
    checks++; if (fault !== 1'b0) begin failures++; $display("FAIL reset.fault got %b want 0", fault); end
    repeat (2) tick();
    checks++; if ((step_en !== 4'b0000) || (busy !== 1'b0)) begin
      failures++; $display("FAIL reset.hold got step_en=%b busy=%b want 0000/0", step_en, busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp_up();
    logic [3:0] pats [4];
    int         gaps [4];
    int         n;
    logic       t_ok, b_ok;
    pats = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    gaps = '{4, 4, 8, 4};
    wait_busy(n);
    checks++; if ((n !== 3) || (busy !== 1'b1)) begin
      failures++; $display("FAIL ramp_up.busy_latency got %0d edges busy=%b want 3 edges busy=1", n, busy);
    end
    for (int i = 0; i < 4; i++) begin
      wait_step(n, t_ok, b_ok);
      checks++; if (step_en !== pats[i]) begin failures++; $display("FAIL ramp_up.pat[%0d] got %b want %b", i, step_en, pats[i]); end
      checks++; if (n !== gaps[i]) begin failures++; $display("FAIL ramp_up.gap[%0d] got %0d want %0d", i, n, gaps[i]); end
      checks++; if (!b_ok) begin failures++; $display("FAIL ramp_up.busy[%0d] got low want high", i); end
      checks++; if (init_rst !== 1'b1) begin failures++; $display("FAIL ramp_up.init_rst[%0d] got %b want 1", i, init_rst); end
    end
    tick();
    checks++; if (init_rst !== 1'b0) begin failures++; $display("FAIL ramp_up.init_rst_fall got %b want 0", init_rst); end
    checks++; if ((busy !== 1'b0) || (step_en !== 4'b1111) || (fault !== 1'b0)) begin
      failures++; $display("FAIL ramp_up.on got busy=%b step_en=%b fault=%b want 0/1111/0", busy, step_en, fault);
    end
  endtask

  task automatic test_ramp_down();
    logic [3:0] pats [4];
    int         n;
    logic       t_ok, b_ok;
    pats = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    en_pwr_off = 1'b1;
    wait_busy(n);
    checks++; if ((n !== 3) || (busy !== 1'b1)) begin
      failures++; $display("FAIL ramp_dn.busy_latency got %0d edges busy=%b want 3 edges busy=1", n, busy);
    end
    for (int i = 0; i < 4; i++) begin
      wait_step(n, t_ok, b_ok);
      checks++; if (step_en !== pats[i]) begin failures++; $display("FAIL ramp_dn.pat[%0d] got %b want %b", i, step_en, pats[i]); end
      checks++; if (n !== 3) begin failures++; $display("FAIL ramp_dn.gap[%0d] got %0d want 3", i, n); end
      checks++; if (!b_ok) begin failures++; $display("FAIL ramp_dn.busy[%0d] got low want high", i); end
    end
    repeat (3) tick();
    checks++; if ((busy !== 1'b0) || (step_en !== 4'b0000) || (init_rst !== 1'b0)) begin
      failures++; $display("FAIL ramp_dn.off got busy=%b step_en=%b init_rst=%b want 0/0000/0", busy, step_en, init_rst);
    end
  endtask

  task automatic test_reversal();
    logic [3:0] pats [6];
    int         gaps [6];
    int         n;
    logic       t_ok, b_ok;
    pats = '{4'b0001, 4'b0011, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    gaps = '{4, 4, 6, 7, 8, 4};
    en_pwr_off = 1'b0;
    wait_busy(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL reversal.busy_latency got %0d want 3", n); end
    for (int i = 0; i < 6; i++) begin
      // Reverse at 0011, then resume once 0001 is reached again.
      if (i == 2) en_pwr_off = 1'b1;
      if (i == 3) en_pwr_off = 1'b0;
      wait_step(n, t_ok, b_ok);
      checks++; if (step_en !== pats[i]) begin failures++; $display("FAIL reversal.pat[%0d] got %b want %b", i, step_en, pats[i]); end
      checks++; if (n !== gaps[i]) begin failures++; $display("FAIL reversal.gap[%0d] got %0d want %0d", i, n, gaps[i]); end
      checks++; if (!t_ok) begin failures++; $display("FAIL reversal.thermo[%0d] got non-thermometer pattern", i); end
      checks++; if (!b_ok) begin failures++; $display("FAIL reversal.busy[%0d] got low want high", i); end
    end
    tick();
    checks++; if ((busy !== 1'b0) || (init_rst !== 1'b0)) begin
      failures++; $display("FAIL reversal.on got busy=%b init_rst=%b want 0/0", busy, init_rst);
    end
  endtask

  task automatic test_roic();
    int   n;
    logic t_ok, b_ok;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) wait_step(n, t_ok, b_ok);
    checks++; if ((step_en !== 4'b0111) || (roic_reset !== 1'b0)) begin
      failures++; $display("FAIL roic.trigger got step_en=%b roic=%b want 0111/0", step_en, roic_reset);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (roic_reset !== 1'b1) begin failures++; $display("FAIL roic.high[%0d] got %b want 1", i, roic_reset); end
    end
    tick();
    checks++; if (roic_reset !== 1'b0) begin failures++; $display("FAIL roic.end got %b want 0", roic_reset); end
  endtask

  task automatic test_reset_mid_ramp();
    int   n;
    logic t_ok, b_ok;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) wait_step(n, t_ok, b_ok);
    tick();
    checks++; if ((step_en !== 4'b0111) || (roic_reset !== 1'b1)) begin
      failures++; $display("FAIL midrst.pre got step_en=%b roic=%b want 0111/1", step_en, roic_reset);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if ((step_en !== 4'b0000) || (init_rst !== 1'b1) || (roic_reset !== 1'b0) || (busy !== 1'b0) || (fault !== 1'b0)) begin
      failures++; $display("FAIL midrst.async got step_en=%b init=%b roic=%b busy=%b fault=%b want 0000/1/0/0/0",
                           step_en, init_rst, roic_reset, busy, fault);
    end
    tick();
    reset = 1'b0;
    wait_busy(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL midrst.restart_latency got %0d want 3", n); end
    wait_step(n, t_ok, b_ok);
    checks++; if ((step_en !== 4'b0001) || (n !== 4) || (init_rst !== 1'b1)) begin
      failures++; $display("FAIL midrst.restart got step_en=%b gap=%0d init=%b want 0001/4/1", step_en, n, init_rst);
    end
  endtask

  task automatic test_pg();
    int   n;
    logic t_ok, b_ok;
    reset = 1'b1;
    pg_in = 4'b1101;
    tick();
    reset = 1'b0;
`ifdef PWR_SEQ_PG_CHECK_EN
    for (int i = 0; i < 2; i++) wait_step(n, t_ok, b_ok);
    checks++; if (step_en !== 4'b0011) begin failures++; $display("FAIL pg.stall got %b want 0011", step_en); end
    wait_step(n, t_ok, b_ok);
    checks++; if ((step_en !== 4'b0000) || (fault !== 1'b1) || (busy !== 1'b0) || (n !== 18)) begin
      failures++; $display("FAIL pg.fault got step_en=%b fault=%b busy=%b edges=%0d want 0000/1/0/18", step_en, fault, busy, n);
    end
    en_pwr_off = 1'b1;
    n = 0;
    do begin tick(); n++; end while ((fault === 1'b1) && (n < 64));
    checks++; if ((fault !== 1'b0) || (n !== 3)) begin
      failures++; $display("FAIL pg.clear got fault=%b edges=%0d want 0/3", fault, n);
    end
`else
    for (int i = 0; i < 4; i++) wait_step(n, t_ok, b_ok);
    checks++; if (step_en !== 4'b1111) begin failures++; $display("FAIL pg.ignored got %b want 1111", step_en); end
    tick();
    checks++; if ((fault !== 1'b0) || (init_rst !== 1'b0)) begin
      failures++; $display("FAIL pg.done got fault=%b init=%b want 0/0", fault, init_rst);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_roic();
    test_reset_mid_ramp();
    test_pg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Parametrised power-rail sequencer for the detector front end. It replaces the fixed six-step init sequencer with an N-step ramp-up/ramp-down engine that has per-step delay classes, mid-sequence reversal, optional power-good supervision and a configurable ROIC reset pulse. It sits between the host control registers (`en_pwr_off`) and the board rail enables. It also generates `init_rst` for the rest of the FPGA.

## Interface
- `NUM_STEPS`, 6: number of sequenced rails (2..16).
- `CNT_W`, 25: delay counter width.
- `DLY_UP`, 1000: ramp-up delay per normal step, in cycles.
- `DLY_DN`, 1000: ramp-down delay per step, in cycles.
- `DLY_SLOW`, 3000: ramp-up delay for steps flagged in `SLOW_MASK`.
- `SLOW_MASK`, 6'b010000: bit k set means step k uses `DLY_SLOW` on ramp-up.
- `RST_STEP`, 4: index of the step whose rise triggers `roic_reset`.
- `RST_PULSE_W`, 4: width of `roic_reset`, in cycles (≥1).
- `PG_TIMEOUT`, 5000: power-good wait limit, in cycles (only with macro).

Ports:
- `fsm_clk` in 1: sequencer clock.
- `reset` in 1: asynchronous, active-high reset.
- `en_pwr_off` in 1: async level; 1 requests rails off, 0 requests rails on.
- `pg_in` in NUM_STEPS: async power-good per rail, active-high.
- `step_en` out NUM_STEPS: rail enables; bit k is step k.
- `init_rst` out 1: system init reset; high until first full power-up.
- `roic_reset` out 1: ROIC reset pulse.
- `busy` out 1: high in RAMP_UP or RAMP_DN.
- `fault` out 1: high in FAULT.

## Operation
- `en_pwr_off` and `pg_in` each pass through a 2-FF synchroniser. All logic uses the synchronised copies (`req_off`, `pg_s`).
- States: OFF, RAMP_UP, ON, RAMP_DN, FAULT. Reset enters OFF.
- Reset values: `step_en`=0, `init_rst`=1, `roic_reset`=0, `busy`=0, `fault`=0, counter=0.
- OFF transitions:
  - `req_off`=0 → RAMP_UP with counter=0.
  - Otherwise hold.
- RAMP_UP:
  - `k` is the count of asserted `step_en` bits.
  - The counter increments until it equals the delay for step k (`DLY_SLOW` if `SLOW_MASK[k]`, else `DLY_UP`).
  - On that cycle `step_en[k]` is set and the counter clears.
  - When `k` reaches `NUM_STEPS` → ON.
  - `req_off`=1 at any point → RAMP_DN. The counter clears and no further bits are set.
- ON:
  - `req_off`=1 → RAMP_DN with counter=0.
  - `init_rst` clears on the first entry to ON and stays 0 until `reset`.
- RAMP_DN:
  - The highest asserted bit clears when the counter equals `DLY_DN`, then the counter clears.
  - When all bits are 0 → OFF.
  - `req_off`=0 → RAMP_UP from the current bit pattern, counter cleared.
- Enable ordering: `step_en` is always thermometer-coded (bits 0..k-1 set). At most one bit changes per cycle, except when entering FAULT.
- ROIC reset: a rising edge of `step_en[RST_STEP]` loads a pulse counter. `roic_reset` is high for exactly `RST_PULSE_W` cycles, starting the next cycle. A re-trigger during the pulse restarts it.
- Arithmetic: delay parameters must fit `CNT_W`. The counter never wraps; it always clears at the terminal value.

## Timing
- Input to state reaction: 2 sync cycles plus 1 register cycle. A change on `en_pwr_off` affects `busy` on the 3rd `fsm_clk` edge.
- On ramp-up, `step_en[k]` rises delay(k)+1 cycles after `step_en[k-1]`. `step_en[0]` rises `DLY_UP`+1 cycles after RAMP_UP entry.
- On ramp-down, successive bits fall `DLY_DN`+1 cycles apart.
- `init_rst` falls 1 cycle after `step_en[NUM_STEPS-1]` rises.
- Simultaneous events:
  - A reversal request on the same cycle as a counter terminal: the reversal wins and the bit does not change.
  - A fault on the same cycle as a reversal: the fault wins.
- `reset` mid-ramp: all outputs go to their reset values immediately (asynchronously), and `init_rst` returns to 1.

## Configuration
- `PWR_SEQ_PG_CHECK_EN` defined:
  - In RAMP_UP, step k (k≥1) asserts only if `pg_s[k-1]`=1 at the counter terminal.
  - Otherwise the counter holds and a wait counter runs. If it exceeds `PG_TIMEOUT` → FAULT.
  - In ON, any `pg_s` bit falling → FAULT.
  - FAULT clears all `step_en` bits in the same cycle and sets `fault`=1. It stays until `req_off`=1, then → OFF with `fault`=0.
- `PWR_SEQ_PG_CHECK_EN` undefined: `pg_in` is ignored, FAULT is unreachable, and `fault` is tied 0.

## Test plan
- Config NUM_STEPS=4, DLY_UP=3, DLY_SLOW=7, SLOW_MASK=4'b0100, hold `en_pwr_off`=0 after reset → `step_en` goes 0001, 0011, 0111, 1111 at intervals of 4, 4, 8, 4 cycles; `init_rst` falls 1 cycle after 1111; `busy` is high throughout the ramp.
- From ON with DLY_DN=2, set `en_pwr_off`=1 → `step_en` goes 0111, 0011, 0001, 0000 at 3-cycle intervals; state ends in OFF; `init_rst` stays 0.
- During ramp-up at `step_en`=0011, set `en_pwr_off`=1, then back to 0 after `step_en`=0001 → ramp-down to 0001, then ramp-up resumes to 1111; no non-thermometer pattern appears.
- RST_STEP=2, RST_PULSE_W=4 → `roic_reset` is high exactly 4 cycles, starting 1 cycle after `step_en[2]` rises.
- With macro, PG_TIMEOUT=10, hold `pg_in[1]`=0 → `step_en` stalls at 0011 and enters FAULT after 10 wait cycles (`step_en`=0, `fault`=1). Set `en_pwr_off`=1 → `fault`=0. Without macro, the same stimulus completes the ramp to 1111.
- Assert `reset` mid-ramp at `step_en`=0111 → all outputs are at reset values before the next edge; after release the sequence restarts from 0000.
